// File: rtl/host_byte_deframer.sv
// Hunts SYNC_BYTE in the host byte stream and assembles big-endian command/address/data words (plus write bursts) for wishbone_master.
// in_ready fires 1 clk after a word's last byte at the earliest; while master_ready=0 the SEND states hold the words and drop byte_ready.
module host_byte_deframer #(
    parameter logic [7:0]  SYNC_BYTE = 8'hCD,
    parameter logic [31:0] TIMEOUT   = 32'd1000,
    parameter logic [3:0]  CMD_WRITE = 4'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic        master_ready,
    output logic        in_ready,
    output logic [31:0] in_command,
    output logic [31:0] in_address,
    output logic [31:0] in_data,
    output logic        busy,
    output logic        frame_error
);

    typedef enum logic [2:0] {HUNT, CMD, ADDR, DATA, SEND, MORE, SEND_MORE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  byte_cnt, byte_cnt_nxt;
    logic [15:0] extra_cnt, extra_cnt_nxt;
    logic [31:0] timer, timer_nxt;
    logic [23:0] shift, shift_nxt;
    logic [31:0] command_nxt, address_nxt, data_nxt;
    logic        rdy_q;
    logic        take;
    logic [31:0] word;

    assign byte_ready = rdy_q;
    assign take       = byte_valid && rdy_q;
    assign word       = {shift, byte_data};
    assign busy       = (state != HUNT);

    always_comb begin
        state_nxt     = state;
        byte_cnt_nxt  = byte_cnt;
        extra_cnt_nxt = extra_cnt;
        timer_nxt     = timer;
        shift_nxt     = shift;
        command_nxt   = in_command;
        address_nxt   = in_address;
        data_nxt      = in_data;
        in_ready      = 1'b0;
        frame_error   = 1'b0;
        case (state)
            HUNT: begin
                if (take && byte_data == SYNC_BYTE) begin
                    state_nxt    = CMD;
                    byte_cnt_nxt = 2'd0;
                    timer_nxt    = TIMEOUT;
                end
            end
            CMD, ADDR, DATA, MORE: begin
                // An expired timer wins over a byte arriving in the same cycle.
                if (timer == 32'd0) begin
                    frame_error  = 1'b1;
                    state_nxt    = HUNT;
                    byte_cnt_nxt = 2'd0;
                end else if (take) begin
                    timer_nxt    = TIMEOUT;
                    shift_nxt    = {shift[15:0], byte_data};
                    byte_cnt_nxt = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        if (state == CMD) begin
                            command_nxt = word;
                            state_nxt   = ADDR;
                        end else if (state == ADDR) begin
                            address_nxt = word;
                            state_nxt   = DATA;
                        end else if (state == DATA) begin
                            data_nxt    = word;
                            state_nxt   = SEND;
                        end else begin
                            data_nxt    = word;
                            state_nxt   = SEND_MORE;
                        end
                    end
                end else begin
                    timer_nxt = timer - 32'd1;
                end
            end
            SEND: begin
                if (master_ready) begin
                    in_ready = 1'b1;
                    if (in_command[3:0] == CMD_WRITE && in_command[31:16] != 16'd0) begin
                        extra_cnt_nxt = in_command[31:16];
                        state_nxt     = MORE;
                        timer_nxt     = TIMEOUT;
                    end else begin
                        state_nxt = HUNT;
                    end
                end
            end
            SEND_MORE: begin
                if (master_ready) begin
                    in_ready      = 1'b1;
                    extra_cnt_nxt = extra_cnt - 16'd1;
                    if (extra_cnt == 16'd1) begin
                        state_nxt = HUNT;
                    end else begin
                        state_nxt = MORE;
                        timer_nxt = TIMEOUT;
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= HUNT;
            byte_cnt   <= 2'd0;
            extra_cnt  <= 16'd0;
            timer      <= 32'd0;
            shift      <= 24'd0;
            in_command <= 32'd0;
            in_address <= 32'd0;
            in_data    <= 32'd0;
            rdy_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            byte_cnt   <= byte_cnt_nxt;
            extra_cnt  <= extra_cnt_nxt;
            timer      <= timer_nxt;
            shift      <= shift_nxt;
            in_command <= command_nxt;
            in_address <= address_nxt;
            in_data    <= data_nxt;
            // Registered so byte_ready is low in reset and rises on the first clock after release.
            rdy_q      <= (state_nxt != SEND) && (state_nxt != SEND_MORE);
        end
    end

endmodule

// File: tb/tb_host_byte_deframer.sv
// Directed and randomized bench for host_byte_deframer; a frame-level model predicts the handed-over word triples.
module tb_host_byte_deframer;

    localparam logic [7:0]  SYNC = 8'hCD;
    localparam logic [31:0] TMO  = 32'd20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        master_ready = 1'b0;
    logic        in_ready;
    logic [31:0] in_command, in_address, in_data;
    logic        busy, frame_error;

    int total = 0;
    int bad = 0;
    int fe_cnt = 0;
    int gi = 0;
    int mr_mode = 1;
    int unsigned max_gap = 0;
    logic [95:0] got_q[$];
    logic [95:0] exp_q[$];
    logic [31:0] words_q[$];

    host_byte_deframer #(.SYNC_BYTE(SYNC), .TIMEOUT(TMO), .CMD_WRITE(4'h1)) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .master_ready(master_ready), .in_ready(in_ready),
        .in_command(in_command), .in_address(in_address), .in_data(in_data),
        .busy(busy), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #2;
        case (mr_mode)
            0:       master_ready = 1'b0;
            1:       master_ready = 1'b1;
            default: master_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    always @(negedge clk) begin
        if (in_ready) got_q.push_back({in_command, in_address, in_data});
        if (frame_error) fe_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        repeat ($urandom_range(0, max_gap)) @(negedge clk);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("byte_accept", 96'(byte_ready), 96'd1);
        @(posedge clk);
        #1 byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    // Model: one triple for the base frame, plus one per extra word only for the write opcode.
    task automatic send_frame(input logic [31:0] cmd, input logic [31:0] addr);
        int n;
        send_byte(SYNC);
        send_word(cmd);
        send_word(addr);
        send_word(words_q[0]);
        exp_q.push_back({cmd, addr, words_q[0]});
        n = (cmd[3:0] == 4'h1) ? int'(cmd[31:16]) : 0;
        for (int i = 1; i <= n; i++) begin
            send_word(words_q[i]);
            exp_q.push_back({cmd, addr, words_q[i]});
        end
    endtask

    task automatic check_drain(input string tag);
        int want;
        want = gi + exp_q.size();
        for (int i = 0; i < 400 && got_q.size() < want; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk({tag, "_count"}, 96'(got_q.size() - gi), 96'(exp_q.size()));
        for (int j = 0; j < exp_q.size() && gi + j < got_q.size(); j++)
            chk({tag, "_word"}, got_q[gi + j], exp_q[j]);
        gi = got_q.size();
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k, fe0;
        logic ok;

        repeat (3) @(negedge clk);
        chk("rst_words", {in_command, in_address, in_data}, 96'd0);
        chk("rst_flags", 96'({byte_ready, in_ready, busy, frame_error}), 96'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_rst", 96'(byte_ready), 96'd1);

        // Read frame: in_ready one clock after the last byte, then idle.
        words_q.delete(); words_q.push_back(32'h0000_0000);
        send_frame(32'h0000_0002, 32'h0000_0100);
        @(negedge clk);
        chk("read_latency", 96'(in_ready), 96'd1);
        @(negedge clk);
        chk("read_idle_after", 96'({in_ready, busy}), 96'd0);
        check_drain("read");

        // Write burst with two extra words.
        words_q.delete();
        words_q.push_back(32'h1111_1111); words_q.push_back(32'h2222_2222); words_q.push_back(32'h3333_3333);
        send_frame(32'h0002_0001, 32'h0100_0000);
        check_drain("write");
        chk("write_ends_hunt", 96'(busy), 96'd0);

        // Garbage before sync; sync values inside data; count ignored for non-write opcode.
        fe0 = fe_cnt;
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
        words_q.delete(); words_q.push_back(32'hCD00_CDCD);
        send_frame(32'h0005_0002, 32'hCDCD_0004);
        check_drain("garbage");
        chk("garbage_no_ferr", 96'(fe_cnt - fe0), 96'd0);

        // Master stall of 50 clocks.
        fe0 = fe_cnt;
        mr_mode = 0;
        words_q.delete(); words_q.push_back(32'hA5A5_5A5A);
        send_frame(32'h0000_0000, 32'h0000_0040);
        ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (byte_ready || in_ready || frame_error) ok = 1'b0;
        end
        chk("stall_quiet", 96'(ok), 96'd1);
        chk("stall_held", {in_command, in_address, in_data}, {32'h0000_0000, 32'h0000_0040, 32'hA5A5_5A5A});
        @(posedge clk);
        #1 mr_mode = 1;
        @(negedge clk);
        chk("stall_release", 96'(in_ready), 96'd1);
        check_drain("stall");
        chk("stall_no_ferr", 96'(fe_cnt - fe0), 96'd0);

        // Timeout after address byte 2; a byte in the expiry cycle is dropped.
        fe0 = fe_cnt;
        send_byte(SYNC);
        send_word(32'h0000_0002);
        send_byte(8'h00);
        send_byte(8'h00);
        k = 0;
        @(negedge clk);
        while (!frame_error && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_clocks", 96'(k), 96'(TMO));
        byte_valid = 1'b1;
        byte_data  = SYNC;
        @(posedge clk);
        #1 byte_valid = 1'b0;
        @(negedge clk);
        chk("timeout_hunt", 96'({busy, frame_error}), 96'd0);
        words_q.delete(); words_q.push_back(32'h1234_5678);
        send_frame(32'h0000_0003, 32'h0000_0ABC);
        check_drain("after_timeout");
        chk("timeout_pulses", 96'(fe_cnt - fe0), 96'd1);

        // Reset in the middle of a write burst.
        send_byte(SYNC);
        send_word(32'h0003_0001);
        send_word(32'h0000_0200);
        send_word(32'hAAAA_0000);
        exp_q.push_back({32'h0003_0001, 32'h0000_0200, 32'hAAAA_0000});
        send_word(32'hAAAA_0001);
        exp_q.push_back({32'h0003_0001, 32'h0000_0200, 32'hAAAA_0001});
        send_byte(8'hAA);
        send_byte(8'hAA);
        #2 rst = 1'b0;
        #1;
        chk("midrst_words", {in_command, in_address, in_data}, 96'd0);
        chk("midrst_flags", 96'({byte_ready, in_ready, busy, frame_error}), 96'd0);
        check_drain("pre_reset");
        rst = 1'b1;
        @(posedge clk);
        #1 chk("midrst_ready", 96'(byte_ready), 96'd1);
        words_q.delete(); words_q.push_back(32'hDEAD_BEEF);
        send_frame(32'h0000_0002, 32'h0000_0010);
        check_drain("post_reset");

        // Randomized frames with gaps, garbage and master stalls.
        fe0 = fe_cnt;
        mr_mode = 2;
        max_gap = 3;
        for (int f = 0; f < 25; f++) begin
            int ng;
            logic [31:0] cmd;
            logic [7:0] g;
            ng = int'($urandom_range(0, 2));
            for (int i = 0; i < ng; i++) begin
                g = 8'($urandom);
                if (g == SYNC) g = 8'h00;
                send_byte(g);
            end
            cmd = $urandom;
            cmd[31:16] = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) cmd[3:0] = 4'h1;
            words_q.delete();
            for (int i = 0; i < 4; i++) words_q.push_back($urandom);
            send_frame(cmd, $urandom);
        end
        check_drain("random");
        chk("random_no_ferr", 96'(fe_cnt - fe0), 96'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
